// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO: FWFT head, level/watermark flags, sticky overrun
module uart_rx_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_AF   = (ADDR_W + 1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic              overrun_q;

  logic do_pop;
  logic do_wr;
  logic drop;

  // A pop frees a slot in the same cycle, so a write into a full FIFO is only
  // dropped when no pop accompanies it.
  assign do_pop = rd_en & ~empty;
  assign do_wr  = wr_en & (~full | do_pop);
  assign drop   = wr_en & ~do_wr;

  // Flags are pure decodes of the registered level counter.
  assign empty       = (level_q == '0);
  assign full        = (level_q == LVL_FULL);
  assign almost_full = (level_q >= LVL_AF);
  assign level       = level_q;
  assign overrun     = overrun_q;
  assign rd_data     = mem[rd_ptr];

  // Storage array; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at 2**ADDR_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy: simultaneous write and pop leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      case ({do_wr, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overrun; a dropped write takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] level;
  logic       overrun;
  logic       ovr_clr;

  int n_cmp;
  int n_fail;
  int mdl_level;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .almost_full(almost_full),
    .level(level),
    .overrun(overrun),
    .ovr_clr(ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs are driven 1 time unit after posedge, so at negedge both the
  // pop request and the current head are stable.
  always @(negedge clk) begin
    if (!reset && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected no entry", rd_data);
      end else begin
        chk("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the committing edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    ovr_clr = clr;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ovr_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_empty"}, {31'h0, empty}, 32'd1);
    chk({tag, "_full"}, {31'h0, full}, 32'd0);
    chk({tag, "_af"}, {31'h0, almost_full}, 32'd0);
    chk({tag, "_level"}, {27'h0, level}, 32'd0);
    chk({tag, "_ovr"}, {31'h0, overrun}, 32'd0);
    chk({tag, "_rd_data"}, {24'h0, rd_data}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    rd_en = 1'b0;
    ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;

    // 1: single byte round trip
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    exp_q.push_back(8'hA5);
    chk("s1_empty", {31'h0, empty}, 32'd0);
    chk("s1_level", {27'h0, level}, 32'd1);
    chk("s1_rd_data", {24'h0, rd_data}, 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s1_empty_after", {31'h0, empty}, 32'd1);
    chk("s1_level_after", {27'h0, level}, 32'd0);

    // 2: fill to full, watermark from 12
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'(i));
      chk("s2_level", {27'h0, level}, 32'(i + 1));
      chk("s2_af", {31'h0, almost_full}, (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk("s2_full", {31'h0, full}, (i == 15) ? 32'd1 : 32'd0);
    end

    // 3: write while full drops and sets overrun; clear; set wins over clear
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("s3_ovr", {31'h0, overrun}, 32'd1);
    chk("s3_level", {27'h0, level}, 32'd16);
    chk("s3_head", {24'h0, rd_data}, 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("s3_ovr_clr", {31'h0, overrun}, 32'd0);
    step(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("s3_set_wins", {31'h0, overrun}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("s3_ovr_clr2", {31'h0, overrun}, 32'd0);

    // 2/3: drain in order, contents untouched by dropped writes
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s2_drain_empty", {31'h0, empty}, 32'd1);
    chk("s2_drain_level", {27'h0, level}, 32'd0);

    // pop while empty ignored; write+pop while empty keeps the write
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_empty_level", {27'h0, level}, 32'd0);
    chk("pop_empty_ovr", {31'h0, overrun}, 32'd0);
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    exp_q.push_back(8'h3C);
    chk("wrpop_empty_level", {27'h0, level}, 32'd1);
    chk("wrpop_empty_data", {24'h0, rd_data}, 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 4: write + pop while full
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      exp_q.push_back(8'(8'h10 + i));
    end
    step(1'b1, 8'h77, 1'b1, 1'b0);
    exp_q.push_back(8'h77);
    chk("s4_level", {27'h0, level}, 32'd16);
    chk("s4_ovr", {31'h0, overrun}, 32'd0);
    chk("s4_head", {24'h0, rd_data}, 32'h11);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s4_empty", {31'h0, empty}, 32'd1);

    // 5: pointer wrap with interleaved traffic
    mdl_level = 0;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      step(1'b1, d, 1'b0, 1'b0);
      exp_q.push_back(d);
      mdl_level++;
    end
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        step(1'b1, d, 1'b0, 1'b0);
        exp_q.push_back(d);
        mdl_level++;
        repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        mdl_level--;
      end else begin
        step(1'b1, d, 1'b1, 1'b0);
        exp_q.push_back(d);
        repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 1'b0, 1'b0);
      end
      chk("s5_level", {27'h0, level}, 32'(mdl_level));
      chk("s5_level_max", {31'h0, (level <= 5'd16)}, 32'd1);
    end

    // 6: async reset mid-stream at level 5
    chk("s6_pre_level", {27'h0, level}, 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("s6");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    exp_q.push_back(8'hA5);
    chk("s6_empty", {31'h0, empty}, 32'd0);
    chk("s6_level", {27'h0, level}, 32'd1);
    chk("s6_rd_data", {24'h0, rd_data}, 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s6_empty_after", {31'h0, empty}, 32'd1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
